uart_encoder: RTL and testbench
===============================

Name: uart_encoder

Overview:
- Synthesizable UART transmitter that drives a line into the SoC's UART RX input (today tied to 1'b1 in the core bench).
- Sits in the bench or a wrapper as the stimulus-side counterpart of the UART-TX monitor.
- Accepts bytes over a valid/ready port, buffers them in a FIFO, and serializes each as 8N1 (8 data bits, no parity, 1 stop bit), LSB first, at a fixed baud rate.

Parameters:
- CLK_FREQ_HZ, 50_000_000: clk frequency in Hz.
- BAUD, 115200: line rate.
- FIFO_DEPTH, 16: byte buffer depth; must be a power of two and >= 2.
- DIV (localparam), (CLK_FREQ_HZ+BAUD/2)/BAUD: cycles per bit; 434 at the defaults. Elaboration error if DIV < 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_data  in  8  byte to send
- i_valid  in  1  i_data is valid
- o_ready  out  1  FIFO can accept a byte; equals !full
- o_tx  out  1  serial line, idle high, registered
- o_busy  out  1  frame in progress or FIFO not empty
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - o_tx=1, o_busy=0, o_level=0, o_ready=1.
  - FSM=IDLE, bit counter=0, baud counter=0, FIFO flushed.
- Push rules:
  - A push happens when i_valid && o_ready at a clk edge.
  - o_ready is a function of full only; it never depends on a same-cycle pop.
  - i_valid while full: the byte is dropped; the sender must hold it.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: o_tx=0 for DIV cycles.
  - DATA: 8 bits, each held DIV cycles, LSB first, shift right.
  - STOP: o_tx=1 for DIV cycles.
- End of STOP:
  - FIFO non-empty: pop and go straight to START (no idle gap between frames).
  - FIFO empty: go to IDLE.
- Latency: a push into an empty FIFO with the FSM in IDLE makes o_tx fall 2 cycles after the push edge (1 cycle FIFO write, 1 cycle pop/register).
- Frame length: exactly 10*DIV cycles, start edge to next start edge, when back-to-back.
- Baud counter:
  - Counts 0..DIV-1, width $clog2(DIV).
  - Wraps to 0 on each bit boundary; restarts at 0 on entry to START.
- o_level: pointer difference with an extra wrap bit; the full range 0..FIFO_DEPTH is representable.
- Simultaneous push and pop: o_level is unchanged and both operations succeed, including when the FIFO holds 1 entry.
- Full: o_level==FIFO_DEPTH, o_ready=0.
- Empty during IDLE: o_tx stays 1 and o_busy=0.
- Reset mid-frame: o_tx=1 on the next edge, the frame is abandoned, and FIFO contents are discarded.
- i_data changes while not pushed are ignored.

Optional Feature:
- Macro: UART_ENCODER_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting DIV cycles.
  - The parity bit is even: XOR of the 8 data bits.
  - Frame = 11*DIV cycles.
- Undefined: no PARITY state; frame = 10*DIV cycles.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE/START/DATA/PARITY/STOP).
  - DATA_BITS=8.
  - Function baud_div(clk_hz, baud) with the rounding rule above.
  - The future receiver in the bench reuses this package.
- Sub-module uart_encoder_fifo: synchronous FIFO with push/pop/full/empty/level, FIFO_DEPTH parameter, and read data registered on pop. Instantiated once.

Test Plan (CLK_FREQ_HZ=1_000_000, BAUD=100_000, so DIV=10):
- Push 0x55 after reset → o_tx low 2 cycles after the push edge; 10-cycle bits 0,1,0,1,0,1,0,1,0,1; o_tx high again; o_busy falls 100 cycles after the start edge.
- Push 0xA5 then 0x3C on consecutive cycles → second start edge exactly 100 cycles after the first, no idle bit; decoded bytes 0xA5, 0x3C in order.
- Hold i_valid continuously from idle → 17 bytes accepted (1 popped, 16 buffered); then o_ready=0 and o_level=16. o_ready returns to 1 the cycle after the next pop.
- Assert rst for 1 cycle in DATA bit 3 of 0x0F with 4 bytes queued → o_tx=1 next cycle, o_level=0, o_busy=0; a fresh push of 0x81 is transmitted correctly.
- Push with o_level=1 while the FSM pops at STOP end → o_level stays 1 and no byte is lost (decoder sees all bytes).
- UART_ENCODER_PARITY_EN: push 0x07 → parity bit 1, frame 110 cycles. Push 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: frame state encoding, data width,
//               and the baud divider rounding helper. Reused by the encoder
//               and by bench-side receivers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_encoder_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_encoder_fifo
// Description : Synchronous byte FIFO. Pointers carry an extra wrap bit so the
//               occupancy covers 0..FIFO_DEPTH. Read data is registered on pop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_encoder_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_encoder_fifo: FIFO_DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; push and pop may happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head entry captured on pop and held until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_data <= '0;
    end else if (do_pop) begin
      pop_data <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_encoder
// Description : UART transmitter, 8N1 LSB first. Bytes enter through a
//               valid/ready port into a FIFO and are serialised back to back.
//               Optional macro UART_ENCODER_PARITY_EN adds an even parity bit
//               between the data bits and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_encoder
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_encoder: CLK_FREQ_HZ/BAUD gives fewer than 2 cycles per bit");
  end

  uart_state_e          state;
  uart_state_e          state_nxt;
  logic [BW-1:0]        baud_cnt;
  logic [BW-1:0]        baud_cnt_nxt;
  logic [CW-1:0]        bit_cnt;
  logic [CW-1:0]        bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 tx_nxt;
  logic                 bit_done;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
`ifdef UART_ENCODER_PARITY_EN
  logic                 par;
  logic                 par_nxt;
`endif

  uart_encoder_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (i_valid),
    .push_data (i_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_level)
  );

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign o_ready  = !fifo_full;
  assign bit_done = (baud_cnt == BAUD_LAST);

  // Next-state, datapath and line-value decode for the frame sequencer.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = bit_done ? '0 : baud_cnt + 1'b1;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    fifo_pop     = 1'b0;
    tx_nxt       = 1'b1;
`ifdef UART_ENCODER_PARITY_EN
    par_nxt      = par;
`endif
    case (state)
      ST_IDLE: begin
        baud_cnt_nxt = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx_nxt = 1'b0;
        // The popped byte is stable in the FIFO read register by now.
        if (bit_done) begin
          state_nxt   = ST_DATA;
          shreg_nxt   = fifo_rdata;
          bit_cnt_nxt = '0;
`ifdef UART_ENCODER_PARITY_EN
          par_nxt     = ^fifo_rdata;
`endif
        end
      end
      ST_DATA: begin
        tx_nxt = shreg[0];
        if (bit_done) begin
          shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_ENCODER_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_ENCODER_PARITY_EN
      ST_PARITY: begin
        tx_nxt = par;
        if (bit_done) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx_nxt = 1'b1;
        // Chain straight into the next start bit when more data waits.
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        baud_cnt_nxt = '0;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_ENCODER_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
`ifdef UART_ENCODER_PARITY_EN
      par      <= par_nxt;
`endif
    end
  end

  // Registered line and busy flag, one cycle behind the sequencer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tx   <= 1'b1;
      o_busy <= 1'b0;
    end else begin
      o_tx   <= tx_nxt;
      o_busy <= (state != ST_IDLE) || !fifo_empty;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_encoder
// Description : Directed bench for uart_encoder at DIV=10 with a line decoder
//               collecting every frame seen on o_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_encoder;

`ifdef UART_ENCODER_PARITY_EN
  localparam int FRAME = 110;
`else
  localparam int FRAME = 100;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic [4:0] o_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [9:0] rxq [$];
  int         stq [$];

  uart_encoder #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_level (o_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: mid-bit sampling on the falling clock edge.
  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    int         ts;
    forever begin
      @(negedge clk);
      if (!rst && o_tx === 1'b0) begin
        ts = cyc;
        d  = '0;
        p  = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          d[i] = o_tx;
        end
`ifdef UART_ENCODER_PARITY_EN
        repeat (10) @(negedge clk);
        p = o_tx;
`endif
        repeat (10) @(negedge clk);
        s = o_tx;
        rxq.push_back({p, s, d});
        stq.push_back(ts);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] rx_get();
    if (rxq.size() > 0) return rxq.pop_front();
    return 10'h3FF;
  endfunction

  function automatic int st_get();
    if (stq.size() > 0) return stq.pop_front();
    return -1;
  endfunction

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("rx_count", rxq.size(), n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((o_busy !== 1'b0 || o_tx !== 1'b1) && k < 3000) begin
      tick();
      k++;
    end
    chk("idle_busy", {31'd0, o_busy}, 0);
    repeat (20) tick();
    rxq.delete();
    stq.delete();
  endtask

  task automatic push1(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    logic [9:0] e;
    int         t0;
    int         t1;
    int         n;
    int         acc;
    int         lows;
    logic       accept;
    logic [7:0] v4 [5];

    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) tick();
    chk("rst_tx", {31'd0, o_tx}, 1);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_level", {27'd0, o_level}, 0);
    chk("rst_ready", {31'd0, o_ready}, 1);
    rst = 1'b0;
    repeat (3) tick();

    // Single byte: latency, bit pattern, busy release.
    i_valid = 1'b1;
    i_data  = 8'h55;
    tick();
    i_valid = 1'b0;
    i_data  = 8'hEE;
    chk("lat_e0", {31'd0, o_tx}, 1);
    tick();
    chk("lat_e1", {31'd0, o_tx}, 1);
    tick();
    chk("lat_e2", {31'd0, o_tx}, 0);
    n = 0;
    while (o_busy && n < 300) begin
      tick();
      n++;
    end
    chk("busy_fall", n, FRAME);
    chk("idle_tx", {31'd0, o_tx}, 1);
    wait_rx(1, 50);
    e = rx_get();
    chk("rx_55", {24'd0, e[7:0]}, 32'h55);
    chk("stop_55", {31'd0, e[8]}, 1);

    // Two consecutive pushes: back-to-back frames, order kept.
    wait_idle();
    i_valid = 1'b1;
    i_data  = 8'hA5;
    tick();
    i_data  = 8'h3C;
    tick();
    i_valid = 1'b0;
    wait_rx(2, 400);
    t0 = st_get();
    t1 = st_get();
    chk("b2b_gap", t1 - t0, FRAME);
    e = rx_get();
    chk("rx_a5", {24'd0, e[7:0]}, 32'hA5);
    e = rx_get();
    chk("rx_3c", {24'd0, e[7:0]}, 32'h3C);
    chk("stop_3c", {31'd0, e[8]}, 1);

    // Continuous valid from idle: fill, then one slot after the first pop.
    wait_idle();
    i_valid = 1'b1;
    i_data  = 8'h10;
    acc     = 0;
    for (int k = 0; k <= FRAME + 2; k++) begin
      accept = o_ready;
      tick();
      if (accept) begin
        acc++;
        i_data = 8'(8'h10 + acc);
      end
      if (k == 16) begin
        chk("fill_count", acc, 17);
        chk("full_ready", {31'd0, o_ready}, 0);
        chk("full_level", {27'd0, o_level}, 16);
      end
      if (k == FRAME) begin
        chk("prepop_ready", {31'd0, o_ready}, 0);
        chk("prepop_level", {27'd0, o_level}, 16);
      end
      if (k == FRAME + 1) begin
        chk("pop_ready", {31'd0, o_ready}, 1);
        chk("pop_level", {27'd0, o_level}, 15);
      end
      if (k == FRAME + 2) begin
        chk("refill_ready", {31'd0, o_ready}, 0);
        chk("refill_level", {27'd0, o_level}, 16);
      end
    end
    i_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("flush_level", {27'd0, o_level}, 0);
    repeat (120) tick();
    rxq.delete();
    stq.delete();

    // Reset in data bit 3 of 0x0F with 4 bytes queued.
    v4[0] = 8'h0F; v4[1] = 8'h11; v4[2] = 8'h22; v4[3] = 8'h33; v4[4] = 8'h44;
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data  = v4[i];
      tick();
    end
    i_valid = 1'b0;
    repeat (43) tick();
    chk("bit3_tx", {31'd0, o_tx}, 1);
    chk("bit3_level", {27'd0, o_level}, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_tx", {31'd0, o_tx}, 1);
    chk("mid_rst_level", {27'd0, o_level}, 0);
    chk("mid_rst_busy", {31'd0, o_busy}, 0);
    chk("mid_rst_ready", {31'd0, o_ready}, 1);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_tx !== 1'b1) lows++;
    end
    chk("abandoned", lows, 0);
    repeat (60) tick();
    rxq.delete();
    stq.delete();
    push1(8'h81);
    wait_rx(1, 300);
    e = rx_get();
    chk("rx_81", {24'd0, e[7:0]}, 32'h81);

    // Push at level 1 on the same edge the sequencer pops at stop end.
    wait_idle();
    i_valid = 1'b1;
    i_data  = 8'hC3;
    tick();
    i_data  = 8'h5A;
    tick();
    i_valid = 1'b0;
    repeat (FRAME - 1) tick();
    chk("pp_level_pre", {27'd0, o_level}, 1);
    push1(8'h96);
    chk("pp_level_post", {27'd0, o_level}, 1);
    wait_rx(3, 500);
    e = rx_get();
    chk("rx_c3", {24'd0, e[7:0]}, 32'hC3);
    e = rx_get();
    chk("rx_5a", {24'd0, e[7:0]}, 32'h5A);
    e = rx_get();
    chk("rx_96", {24'd0, e[7:0]}, 32'h96);
    t0 = st_get();
    t0 = st_get();
    t1 = st_get();
    chk("pp_gap", t1 - t0, FRAME);

`ifdef UART_ENCODER_PARITY_EN
    // Even parity bit and lengthened frame.
    wait_idle();
    i_valid = 1'b1;
    i_data  = 8'h07;
    tick();
    i_data  = 8'h03;
    tick();
    i_valid = 1'b0;
    wait_rx(2, 400);
    t0 = st_get();
    t1 = st_get();
    chk("par_frame", t1 - t0, 110);
    e = rx_get();
    chk("rx_07", {24'd0, e[7:0]}, 32'h07);
    chk("par_07", {31'd0, e[9]}, 1);
    e = rx_get();
    chk("rx_03", {24'd0, e[7:0]}, 32'h03);
    chk("par_03", {31'd0, e[9]}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
